// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: freezes, load-use bubble, jump flush,
// data-cache miss handshake toward main memory, and saturating stall/miss statistics.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             mem_access,
  input  logic             cache_hit,
  input  logic             mem_ready,
  input  logic             idex_mem_to_reg,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic [1:0]       jump_id,
  output logic             freeze_if_id,
  output logic             freeze_id_ex,
  output logic             freeze_ex_mem,
  output logic             freeze_mem_wb,
  output logic             pc_write,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             mem_req,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {RUN, REQ, WAIT, RETRY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             miss, freeze_all, load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    miss       = (state_q == RUN) & mem_access & ~cache_hit;
    freeze_all = miss | (state_q != RUN);
    load_use   = idex_mem_to_reg & (idex_rt != 5'd0) &
                 ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));
  end

  // Mealy pipeline controls; a miss or refill in flight overrides hazards and jumps
  always_comb begin
    freeze_if_id  = 1'b0;
    freeze_id_ex  = 1'b0;
    freeze_ex_mem = 1'b0;
    freeze_mem_wb = 1'b0;
    pc_write      = 1'b1;
    bubble_id_ex  = 1'b0;
    flush_if_id   = 1'b0;
    if (freeze_all) begin
      freeze_if_id  = 1'b1;
      freeze_id_ex  = 1'b1;
      freeze_ex_mem = 1'b1;
      freeze_mem_wb = 1'b1;
      pc_write      = 1'b0;
    end else if (load_use) begin
      freeze_if_id = 1'b1;
      pc_write     = 1'b0;
      bubble_id_ex = 1'b1;
    end else if (jump_id != 2'd0) begin
      flush_if_id = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (miss) state_d = REQ;
      REQ:     state_d = mem_ready ? RETRY : WAIT;
      WAIT:    if (mem_ready) state_d = RETRY;
      RETRY:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    miss_d  = miss_q;
    if (freeze_all | bubble_id_ex) stall_d = sat_inc(stall_q);
    if (miss) miss_d = sat_inc(miss_q);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= RUN;
      stall_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      miss_q  <= miss_d;
    end
  end

  assign mem_req      = (state_q == REQ) | (state_q == WAIT);
  assign stall_cycles = stall_q;
  assign miss_count   = miss_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, jumps, short/long misses, saturation, async reset.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_b;
  logic        mem_access, cache_hit, mem_ready;
  logic        idex_mem_to_reg, ifid_uses_rt;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic [1:0]  jump_id;
  logic        freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb;
  logic        pc_write, bubble_id_ex, flush_if_id, mem_req;
  logic [15:0] stall_cycles, miss_count;
  logic [7:0]  ov;

  int checks   = 0;
  int failures = 0;
  int exp_stall;
  int exp_miss;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_b(rst_b),
    .mem_access(mem_access), .cache_hit(cache_hit), .mem_ready(mem_ready),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .jump_id(jump_id),
    .freeze_if_id(freeze_if_id), .freeze_id_ex(freeze_id_ex),
    .freeze_ex_mem(freeze_ex_mem), .freeze_mem_wb(freeze_mem_wb),
    .pc_write(pc_write), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .mem_req(mem_req), .stall_cycles(stall_cycles), .miss_count(miss_count)
  );

  // {fIF, fID, fEX, fMEM, pc_write, bubble, flush, mem_req}
  assign ov = {freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb,
               pc_write, bubble_id_ex, flush_if_id, mem_req};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_access = 0; cache_hit = 0; mem_ready = 0;
    idex_mem_to_reg = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_uses_rt = 0; jump_id = 0;
  endtask

  // Check outputs mid-cycle, then advance just past the next rising edge.
  task automatic step_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, {24'd0, ov}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_b = 1'b1;
    #1 rst_b = 1'b0;
    #2;
    chk("reset_outputs", {24'd0, ov}, 32'h08);
    chk("reset_stall", {16'd0, stall_cycles}, 32'd0);
    chk("reset_miss", {16'd0, miss_count}, 32'd0);
    #9 rst_b = 1'b1;
    @(posedge clk);
    #1;
    exp_stall = 0;
    exp_miss  = 0;

    // Load-use on rs
    idex_mem_to_reg = 1; idex_rt = 5; ifid_rs = 5;
    step_chk("loaduse_rs", 8'h84);
    exp_stall++;
    idle();
    step_chk("loaduse_cleared", 8'h08);
    chk("stall_after_loaduse", {16'd0, stall_cycles}, exp_stall);

    // Load to $0 never stalls
    idex_mem_to_reg = 1; idex_rt = 0; ifid_rs = 0;
    step_chk("load_r0", 8'h08);

    // rt match only counts when rt is read
    idex_mem_to_reg = 1; idex_rt = 7; ifid_rt = 7; ifid_rs = 3; ifid_uses_rt = 0;
    step_chk("rt_unused", 8'h08);
    ifid_uses_rt = 1;
    step_chk("loaduse_rt", 8'h84);
    exp_stall++;
    idle();
    chk("stall_after_rt", {16'd0, stall_cycles}, exp_stall);

    // Miss with immediate mem_ready
    mem_access = 1; cache_hit = 0;
    step_chk("miss_c0", 8'hF0);
    mem_ready = 1;
    step_chk("miss_c1_req", 8'hF1);
    mem_ready = 0; cache_hit = 1;
    step_chk("miss_c2_retry", 8'hF0);
    step_chk("miss_c3_run", 8'h08);
    exp_stall += 3; exp_miss++;
    idle();
    chk("miss_count_short", {16'd0, miss_count}, exp_miss);
    chk("stall_short", {16'd0, stall_cycles}, exp_stall);

    // Long miss: ready 10 cycles later; hazards and jumps suppressed meanwhile
    for (int i = 0; i <= 12; i++) begin
      idle();
      mem_access = (i == 0) || (i >= 11);
      cache_hit  = (i >= 11);
      mem_ready  = (i == 10);
      if (i == 5) begin
        idex_mem_to_reg = 1; idex_rt = 9; ifid_rs = 9; jump_id = 2;
      end
      if (i == 0)       step_chk($sformatf("long_c%0d", i), 8'hF0);
      else if (i <= 10) step_chk($sformatf("long_c%0d", i), 8'hF1);
      else if (i == 11) step_chk($sformatf("long_c%0d", i), 8'hF0);
      else              step_chk($sformatf("long_c%0d", i), 8'h08);
    end
    exp_stall += 12; exp_miss++;
    idle();
    chk("miss_count_long", {16'd0, miss_count}, exp_miss);
    chk("stall_long", {16'd0, stall_cycles}, exp_stall);

    // Jump together with load-use: bubble first, flush next cycle
    idex_mem_to_reg = 1; idex_rt = 4; ifid_rs = 4; jump_id = 1;
    step_chk("jump_loaduse", 8'h84);
    exp_stall++;
    idex_mem_to_reg = 0;
    step_chk("jump_flush", 8'h0A);
    idle();
    step_chk("after_jump", 8'h08);
    chk("stall_jump", {16'd0, stall_cycles}, exp_stall);

    // Park in WAIT long enough to saturate the stall counter
    mem_access = 1; cache_hit = 0;
    step_chk("sat_miss", 8'hF0);
    idle();
    repeat (65600) @(posedge clk);
    #1;
    chk("stall_saturated", {16'd0, stall_cycles}, 32'hFFFF);
    @(negedge clk);
    chk("wait_outputs", {24'd0, ov}, 32'hF1);
    @(posedge clk);
    #1;
    chk("stall_stays_sat", {16'd0, stall_cycles}, 32'hFFFF);

    // Asynchronous reset while in WAIT
    #2 rst_b = 1'b0;
    #1;
    chk("rst_wait_outputs", {24'd0, ov}, 32'h08);
    chk("rst_wait_stall", {16'd0, stall_cycles}, 32'd0);
    chk("rst_wait_miss", {16'd0, miss_count}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    step_chk("post_reset_run", 8'h08);
    chk("post_reset_stall", {16'd0, stall_cycles}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
